// File: rtl/ge_fitness_pkg.sv
// Shared constants and state encoding for the GE full-adder fitness scheduler.
package ge_fitness_pkg;

    localparam int LANES     = 16;
    localparam int MAX_SCORE = 64;

    // Lane i of each vector carries bit k of i, so all 16 {a,b} pairs appear once.
    localparam logic [15:0] STIM_A1 = 16'hFF00;
    localparam logic [15:0] STIM_A0 = 16'hF0F0;
    localparam logic [15:0] STIM_B1 = 16'hCCCC;
    localparam logic [15:0] STIM_B0 = 16'hAAAA;

    localparam logic [15:0] GOLD_Y3 = 16'h0000;
    localparam logic [15:0] GOLD_Y2 = 16'hEC80;
    localparam logic [15:0] GOLD_Y1 = 16'h936C;
    localparam logic [15:0] GOLD_Y0 = 16'h5A5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_SCORE,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/ge_popcount16.sv
// Combinational population count of a 16-bit word.
module ge_popcount16 (
    input  logic [15:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, din[i]};
        end
    end

endmodule

// File: rtl/ge_fitness_sched.sv
// Round-robin evaluation controller: drives exhaustive adder stimulus to one
// candidate at a time, captures its outputs and returns a fitness score.
//
// state     | meaning
// ST_IDLE   | stimulus at 0, arbitrate pending requests
// ST_DRIVE  | stimulus applied, settle down-counter running
// ST_SAMPLE | capture candidate outputs
// ST_SCORE  | compare captures against golden outputs
// ST_RESULT | result presented until accepted
module ge_fitness_sched
    import ge_fitness_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SETTLE  = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     cand_sel,
    output logic [15:0]        a1,
    output logic [15:0]        a0,
    output logic [15:0]        b1,
    output logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [6:0]         res_score,
    output logic [19:0]        res_score_y
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]       rst_sync;
    logic             rst_sync_n;
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_nxt, win_idx;
    logic             win_found, grant_go;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      cap_y3, cap_y2, cap_y1, cap_y0;
    logic [4:0]       pc3, pc2, pc1, pc0;
    logic [4:0]       sc3, sc2, sc1, sc0;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_sync_n = rst_sync[1];

    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
        ptr_nxt = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        grant_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_DRIVE;
                    grant_go = 1'b1;
                end
            end
            ST_DRIVE:  if (cnt_q == '0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_SCORE;
            ST_SCORE:  state_d = ST_RESULT;
            ST_RESULT: if (res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign res_valid = (state_q == ST_RESULT);
    assign a1 = (state_q != ST_IDLE) ? STIM_A1 : 16'h0000;
    assign a0 = (state_q != ST_IDLE) ? STIM_A0 : 16'h0000;
    assign b1 = (state_q != ST_IDLE) ? STIM_B1 : 16'h0000;
    assign b0 = (state_q != ST_IDLE) ? STIM_B0 : 16'h0000;

    ge_popcount16 u_pc3 (.din(cap_y3 ^ GOLD_Y3), .cnt(pc3));
    ge_popcount16 u_pc2 (.din(cap_y2 ^ GOLD_Y2), .cnt(pc2));
    ge_popcount16 u_pc1 (.din(cap_y1 ^ GOLD_Y1), .cnt(pc1));
    ge_popcount16 u_pc0 (.din(cap_y0 ^ GOLD_Y0), .cnt(pc0));

    assign sc3 = 5'(LANES) - pc3;
    assign sc2 = 5'(LANES) - pc2;
    assign sc1 = 5'(LANES) - pc1;
    assign sc0 = 5'(LANES) - pc0;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt         <= '0;
            cand_sel    <= '0;
            res_id      <= '0;
            res_score   <= '0;
            res_score_y <= '0;
            cap_y3      <= '0;
            cap_y2      <= '0;
            cap_y1      <= '0;
            cap_y0      <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= '0;
            if (grant_go) begin
                gnt[win_idx] <= 1'b1;
                cand_sel     <= win_idx;
                res_id       <= win_idx;
                ptr_q        <= ptr_nxt;
                cnt_q        <= CNT_W'(SETTLE - 1);
            end
            if (state_q == ST_DRIVE && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (state_q == ST_SAMPLE) begin
                cap_y3 <= y3;
                cap_y2 <= y2;
                cap_y1 <= y1;
                cap_y0 <= y0;
            end
            if (state_q == ST_SCORE) begin
                res_score_y <= {sc3, sc2, sc1, sc0};
                res_score   <= 7'(sc3) + 7'(sc2) + 7'(sc1) + 7'(sc0);
            end
        end
    end

endmodule

// File: tb/tb_ge_fitness_sched.sv
// Directed bench for ge_fitness_sched with hand-computed fitness values.
module tb_ge_fitness_sched;

    localparam int NUM_REQ = 4;
    localparam int SETTLE  = 2;
    localparam int IDW     = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     cand_sel;
    logic [15:0]        a1, a0, b1, b0;
    logic [15:0]        y3, y2, y1, y0;
    logic               res_valid;
    logic               res_ready;
    logic [IDW-1:0]     res_id;
    logic [6:0]         res_score;
    logic [19:0]        res_score_y;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ge_fitness_sched #(.NUM_REQ(NUM_REQ), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .cand_sel(cand_sel),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_score(res_score), .res_score_y(res_score_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int t);
        int n = 0;
        while (gnt == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_seen", {31'b0, gnt != '0}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_valid(output int t);
        int n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", {31'b0, res_valid}, 32'd1);
        t = cyc;
    endtask

    task automatic eval(input logic [3:0] rq, input logic [15:0] v3, input logic [15:0] v2,
                        input logic [15:0] v1, input logic [15:0] v0, input int exp_id,
                        input logic [19:0] exp_sy, input logic [6:0] exp_s);
        int tg, tv;
        y3 = v3; y2 = v2; y1 = v1; y0 = v0;
        req = rq;
        res_ready = 1'b0;
        @(negedge clk);
        wait_gnt(tg);
        chk("gnt_slot", gnt, 32'd1 << exp_id);
        chk("cand_sel", cand_sel, exp_id);
        req = '0;
        chk("stim_a1", a1, 16'hFF00);
        chk("stim_a0", a0, 16'hF0F0);
        chk("stim_b1", b1, 16'hCCCC);
        chk("stim_b0", b0, 16'hAAAA);
        @(negedge clk);
        chk("gnt_pulse", gnt, 0);
        wait_valid(tv);
        chk("latency", tv - tg, SETTLE + 2);
        chk("res_id", res_id, exp_id);
        chk("res_score_y", res_score_y, exp_sy);
        chk("res_score", res_score, exp_s);
        res_ready = 1'b1;
        @(negedge clk);
        chk("valid_clr", res_valid, 0);
        chk("stim_idle", a1, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        int tg, tv, tprev;
        logic [6:0] held;
        rst_n = 1'b0;
        req = '0;
        res_ready = 1'b0;
        y3 = '0; y2 = '0; y1 = '0; y0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_cand_sel", cand_sel, 0);
        chk("rst_a1", a1, 0);
        chk("rst_b0", b0, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_score", res_score, 0);
        chk("rst_score_y", res_score_y, 0);
        rst_n = 1'b1;

        eval(4'b0001, 16'h0000, 16'hEC80, 16'h936C, 16'h5A5A, 0,
             {5'd16, 5'd16, 5'd16, 5'd16}, 7'd64);
        eval(4'b0100, 16'h8000, 16'h0000, 16'hAA00, 16'hA000, 2,
             {5'd15, 5'd10, 5'd8, 5'd6}, 7'd39);
        eval(4'b0010, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1,
             {5'd0, 5'd6, 5'd8, 5'd8}, 7'd22);

        // Backpressure: pointer sits at 2 after the last grant to slot 1.
        y3 = 16'h0000; y2 = 16'hEC80; y1 = 16'h936C; y0 = 16'h5A5A;
        req = 4'b1111;
        @(negedge clk);
        wait_gnt(tg);
        chk("bp_gnt", gnt, 4'b0100);
        wait_valid(tv);
        held = res_score;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", res_valid, 1);
            chk("bp_score_hold", res_score, held);
            chk("bp_no_gnt", gnt, 0);
        end
        chk("bp_score", held, 64);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_clr", res_valid, 0);
        @(negedge clk);
        chk("bp_next_gnt", gnt, 4'b1000);
        wait_valid(tv);
        @(negedge clk);

        // Abort mid-DRIVE with reset.
        wait_gnt(tg);
        chk("pre_rst_gnt", gnt, 4'b0001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_a1", a1, 0);
        chk("abort_b1", b1, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_cand_sel", cand_sel, 0);
        repeat (2) @(negedge clk);
        chk("abort_no_result", res_valid, 0);
        rst_n = 1'b1;

        // Fairness from a freshly reset pointer.
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(tg);
            chk("rr_gnt", gnt, 32'd1 << (k % NUM_REQ));
            if (k > 0) chk("rr_interval", tg - tprev, SETTLE + 4);
            tprev = tg;
            wait_valid(tv);
            chk("rr_latency", tv - tg, SETTLE + 2);
            chk("rr_res_id", res_id, k % NUM_REQ);
            @(negedge clk);
        end

        req = '0;
        res_ready = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ge_fitness_sched.md
Name: ge_fitness_sched

Overview:
- Evaluation controller for GE-evolved 2-bit full-adder individuals. Each individual is combinational and bit-sliced: 16 lanes, one lane per input combination, ports a1/a0/b1/b0 -> y3..y2..y0.
- Round-robin arbitrates NUM_REQ candidate slots onto one shared evaluation path. Drives the exhaustive stimulus, waits a settle time, samples the selected candidate's outputs and scores them against golden constants.
- Returns the fitness through a valid/ready handshake.
- Sits between the population buffer/harness mux and the GE fitness collector.

Parameters:
- NUM_REQ, 4, number of candidate slots/requesters (2..16).
- SETTLE, 2, cycles stimulus is held before sampling (>=1).
- IDW, $clog2(NUM_REQ), width of candidate index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-slot evaluation request; level, held until granted.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse when a slot is accepted.
- cand_sel  out  IDW  index of candidate whose y* the external mux returns.
- a1, a0, b1, b0  out  16 each  bit-sliced stimulus to the selected candidate.
- y3, y2, y1, y0  in  16 each  candidate outputs (muxed by cand_sel).
- res_valid  out  1  result available.
- res_ready  in  1  collector accepts the result.
- res_id  out  IDW  slot index of the result.
- res_score  out  7  total correct bits, 0..64.
- res_score_y  out  20  per-output correct-lane counts {y3,y2,y1,y0}, 5 bits each, 0..16.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE; gnt=0; cand_sel=0; a*/b*=16'h0000.
  - res_valid=0; res_id=0; res_score=0; res_score_y=0.
  - Round-robin pointer=0.
- States: IDLE -> DRIVE -> SAMPLE -> SCORE -> RESULT -> IDLE.
- IDLE:
  - If any req is set, grant the first requester at or after the pointer, wrapping.
  - Pulse gnt for that slot, latch cand_sel/res_id, set pointer to winner+1 mod NUM_REQ, go to DRIVE.
  - If no req is set, stay in IDLE with stimulus at 0.
- DRIVE:
  - Stimulus is constant: a1=16'hFF00, a0=16'hF0F0, b1=16'hCCCC, b0=16'hAAAA.
  - Lane i sees a={a1,a0}, b={b1,b0}, taken from bits of i.
  - Hold SETTLE cycles (counter), then go to SAMPLE.
- SAMPLE: register y3..y0 into capture registers; go to SCORE next cycle.
- SCORE:
  - Per output k: mismatch = cap_yk ^ GOLD_Yk; score_yk = 16 - popcount(mismatch).
  - res_score is the sum of the four scores.
  - One cycle; may be split across two cycles internally if total latency stays fixed.
  - Go to RESULT with res_valid=1.
- Golden constants: GOLD_Y3=16'h0000, GOLD_Y2=16'hEC80, GOLD_Y1=16'h936C, GOLD_Y0=16'h5A5A (correct 2-bit sum, carry out on y2).
- RESULT:
  - res_* is held stable while res_valid=1 && !res_ready.
  - On res_valid && res_ready: clear res_valid and go to IDLE.
  - Stimulus returns to 0 in IDLE.
- Latency: grant to res_valid = SETTLE+2 cycles. Back-to-back throughput is one evaluation per SETTLE+4 cycles with res_ready tied high.
- Boundary conditions:
  - A req deasserted after grant has no effect; the evaluation completes.
  - A req from the slot being evaluated is not re-granted until the next IDLE arbitration.
  - Fairness: with all req high, grants are cyclic 0,1,...,NUM_REQ-1,0.
  - Score saturation is impossible (max 64 fits 7 bits); no wrap.
  - rst_n asserted mid-evaluation aborts immediately: outputs go to reset values and no result is emitted.
  - X on y* inputs is not filtered.

Decomposition:
- Package ge_fitness_pkg holds:
  - stimulus constants STIM_A1/A0/B1/B0;
  - GOLD_Y3..GOLD_Y0;
  - LANES=16, MAX_SCORE=64;
  - state enum typedef.
- One sub-module, ge_popcount16: combinational 16-bit popcount returning 5 bits, instantiated four times.

Test Plan:
- Ideal adder (y0=5A5A, y1=936C, y2=EC80, y3=0000) on slot 0 -> res_id=0, res_score=64, res_score_y={16,16,16,16}.
- Candidate y0=A000, y1=AA00, y2=0000, y3=8000 -> res_score_y={15,10,8,6}, res_score=39.
- All outputs stuck 16'hFFFF -> y3=0, y2=6, y1=8, y0=8, total 22.
- req=4'b1111 held, res_ready=1 -> gnt sequence slots 0,1,2,3,0; each gnt-to-valid = SETTLE+2 cycles.
- res_ready held low 5 cycles in RESULT -> res_valid and res_* stable, no new gnt; on ready, IDLE then next grant.
- rst_n pulsed low during DRIVE -> immediate stimulus=0 and res_valid=0; after release, pointer=0 and slot 0 is granted first.
